// File: rtl/rle_symbol_gen_pkg.sv
// Shared types for the entropy-coding front end.
//   SYM_DATA_W : coefficient width the symbol record is sized for
//   SIZE_W     : width of the VLI size category field
//   state_t    : run-length FSM states
//   sym_t      : one output symbol {is_dc, is_eob, is_zrl, run, size, vli}
package entropy_pkg;

  localparam int SYM_DATA_W = 11;
  localparam int SIZE_W     = $clog2(SYM_DATA_W + 2);

  typedef enum logic [1:0] {
    S_DC    = 2'd0,
    S_AC    = 2'd1,
    S_FLUSH = 2'd2,
    S_EOB   = 2'd3
  } state_t;

  typedef struct packed {
    logic                  is_dc;
    logic                  is_eob;
    logic                  is_zrl;
    logic [3:0]            run;
    logic [SIZE_W-1:0]     size;
    logic [SYM_DATA_W-1:0] vli;
  } sym_t;

  function automatic sym_t pack_sym(input logic                  dc,
                                    input logic                  eob,
                                    input logic                  zrl,
                                    input logic [3:0]            run,
                                    input logic [SIZE_W-1:0]     size,
                                    input logic [SYM_DATA_W-1:0] vli);
    sym_t s;
    s.is_dc  = dc;
    s.is_eob = eob;
    s.is_zrl = zrl;
    s.run    = run;
    s.size   = size;
    s.vli    = vli;
    return s;
  endfunction

endpackage

// File: rtl/rle_symbol_gen_if.sv
// Coefficient-in / symbol-out handshake bundle for rle_symbol_gen.
//   in_valid/in_ready/in_data/in_comp : coefficient stream (zigzag order)
//   out_valid/out_ready/out_sym       : symbol stream
//   master : upstream producer + downstream consumer side
//   slave  : the symbol generator itself
interface rle_symbol_gen_if #(
  parameter int DATA_WIDTH = 11,
  parameter int NUM_COMP   = 3
);
  import entropy_pkg::*;

  localparam int COMP_W = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic [COMP_W-1:0]            in_comp;
  logic                         out_valid;
  logic                         out_ready;
  sym_t                         out_sym;

  modport master (
    output in_valid, in_data, in_comp, out_ready,
    input  in_ready, out_valid, out_sym
  );

  modport slave (
    input  in_valid, in_data, in_comp, out_ready,
    output in_ready, out_valid, out_sym
  );

endinterface

// File: rtl/rle_symbol_gen_vli.sv
// vli_sizer: combinational size-category / VLI encoder.
//   v    : signed operand (W bits)
//   size : bit length of |v|, 0 for v == 0
//   vli  : v for v > 0, (v-1) masked to its low size bits for v < 0,
//          upper bits zero; truncated to VW bits
module vli_sizer #(
  parameter int W  = 12,
  parameter int SW = $clog2(W + 1),
  parameter int VW = W
) (
  input  logic signed [W-1:0] v,
  output logic [SW-1:0]       size,
  output logic [VW-1:0]       vli
);

  logic [W-1:0] mag;
  logic [W-1:0] vm1;
  logic [W-1:0] mask;

  always_comb begin
    // Two's-complement negate of the most negative value still yields the
    // correct unsigned magnitude in W bits.
    mag  = v[W-1] ? -v : v;
    size = '0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) size = SW'(i + 1);
    end
    mask = '0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(size)) mask[i] = 1'b1;
    end
    vm1 = v[W-1] ? (v - W'(1)) : v;
    vli = VW'(vm1 & mask);
  end

endmodule

// File: rtl/rle_symbol_gen.sv
// rle_symbol_gen: turns a stream of 8x8 zigzag-ordered quantised coefficients
// into DC-difference, run/size/VLI, ZRL and EOB symbols.
//   clk, rst : clock, asynchronous active-high reset
//   dc_clr   : synchronous clear of every component's DC predictor
//   bus      : slave side of rle_symbol_gen_if (coefficients in, symbols out)
module rle_symbol_gen
  import entropy_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int NUM_COMP   = 3,
  parameter int BLOCK_LEN  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dc_clr,
  rle_symbol_gen_if.slave  bus
);

  localparam int COMP_W = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;
  localparam int IDX_W  = $clog2(BLOCK_LEN);
  localparam int OP_W   = DATA_WIDTH + 1;

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] pred [NUM_COMP];
  logic [3:0]                   run;
  logic [1:0]                   zrl_pend;
  logic [IDX_W-1:0]             index;
  sym_t                         pend_sym;
  logic                         pend_last;
  sym_t                         sym_p0;
  logic                         vld_p0;

  logic                         can_load;
  logic                         in_ready;
  logic                         accept;
  logic [COMP_W-1:0]            comp_sel;
  logic signed [DATA_WIDTH-1:0] pred_sel;
  logic signed [OP_W-1:0]       diff;
  logic signed [OP_W-1:0]       op;
  logic [SIZE_W-1:0]            op_size;
  logic [SYM_DATA_W-1:0]        op_vli;
  logic                         is_zero;
  logic                         is_last;
  sym_t                         coef_sym;

  always_comb begin
    can_load = !vld_p0 || bus.out_ready;
    in_ready = !rst && (state == S_DC || state == S_AC) && can_load;
    accept   = bus.in_valid && in_ready;
    // Out-of-range component IDs fall back to component 0.
    comp_sel = (int'(bus.in_comp) < NUM_COMP) ? bus.in_comp : '0;
    // A clear in the same cycle makes the incoming DC predict from zero.
    pred_sel = dc_clr ? '0 : pred[comp_sel];
    diff     = {bus.in_data[DATA_WIDTH-1], bus.in_data}
             - {pred_sel[DATA_WIDTH-1], pred_sel};
    op       = (state == S_DC) ? diff : {bus.in_data[DATA_WIDTH-1], bus.in_data};
    is_zero  = (bus.in_data == '0);
    is_last  = (index == IDX_W'(BLOCK_LEN - 1));
    coef_sym = pack_sym(state == S_DC, 1'b0, 1'b0,
                        (state == S_DC) ? 4'd0 : run, op_size, op_vli);
  end

  vli_sizer #(
    .W  (OP_W),
    .SW (SIZE_W),
    .VW (SYM_DATA_W)
  ) u_vli (
    .v    (op),
    .size (op_size),
    .vli  (op_vli)
  );

  // Stage p0: FSM and registered symbol output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_DC;
      for (int i = 0; i < NUM_COMP; i++) pred[i] <= '0;
      run       <= '0;
      zrl_pend  <= '0;
      index     <= '0;
      pend_sym  <= '0;
      pend_last <= 1'b0;
      sym_p0    <= '0;
      vld_p0    <= 1'b0;
    end else begin
      if (vld_p0 && bus.out_ready) vld_p0 <= 1'b0;
      if (dc_clr) begin
        for (int i = 0; i < NUM_COMP; i++) pred[i] <= '0;
      end

      case (state)
        S_DC: begin
          if (accept) begin
            sym_p0   <= coef_sym;
            vld_p0   <= 1'b1;
            if (!dc_clr) pred[comp_sel] <= bus.in_data;
            index    <= IDX_W'(1);
            run      <= '0;
            zrl_pend <= '0;
            state    <= S_AC;
          end
        end

        S_AC: begin
          if (accept) begin
            index <= is_last ? '0 : index + 1'b1;
            if (is_zero) begin
              if (is_last) begin
                // Trailing zeros are covered by EOB; pending ZRLs are dropped.
                run      <= '0;
                zrl_pend <= '0;
                state    <= S_EOB;
              end else if (run == 4'd15) begin
                run      <= '0;
                zrl_pend <= zrl_pend + 2'd1;
              end else begin
                run <= run + 4'd1;
              end
            end else begin
              run <= '0;
              if (zrl_pend == 2'd0) begin
                sym_p0 <= coef_sym;
                vld_p0 <= 1'b1;
                state  <= is_last ? S_DC : S_AC;
              end else begin
                pend_sym  <= coef_sym;
                pend_last <= is_last;
                state     <= S_FLUSH;
              end
            end
          end
        end

        S_FLUSH: begin
          if (can_load) begin
            vld_p0 <= 1'b1;
            if (zrl_pend != 2'd0) begin
              sym_p0   <= pack_sym(1'b0, 1'b0, 1'b1, 4'd15, '0, '0);
              zrl_pend <= zrl_pend - 2'd1;
            end else begin
              sym_p0 <= pend_sym;
              state  <= pend_last ? S_DC : S_AC;
            end
          end
        end

        S_EOB: begin
          if (can_load) begin
            sym_p0 <= pack_sym(1'b0, 1'b1, 1'b0, 4'd0, '0, '0);
            vld_p0 <= 1'b1;
            state  <= S_DC;
          end
        end

        default: state <= S_DC;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p0;
  assign bus.out_sym   = sym_p0;

endmodule

// File: tb/tb_rle_symbol_gen.sv
// Scoreboard bench for rle_symbol_gen: stimulus pushes hand-computed expected
// symbols into a queue; a monitor pops and compares on every output handshake.
module tb_rle_symbol_gen;
  import entropy_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic dc_clr;

  rle_symbol_gen_if #(.DATA_WIDTH(11), .NUM_COMP(3)) bus ();

  rle_symbol_gen #(
    .DATA_WIDTH (11),
    .NUM_COMP   (3),
    .BLOCK_LEN  (64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .dc_clr (dc_clr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  sym_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   stall_arm = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic sym_t e_dc(input int size, input int vli);
    sym_t s = '0;
    s.is_dc = 1'b1;
    s.size  = size[SIZE_W-1:0];
    s.vli   = vli[SYM_DATA_W-1:0];
    return s;
  endfunction

  function automatic sym_t e_ac(input int run, input int size, input int vli);
    sym_t s = '0;
    s.run  = run[3:0];
    s.size = size[SIZE_W-1:0];
    s.vli  = vli[SYM_DATA_W-1:0];
    return s;
  endfunction

  function automatic sym_t e_zrl();
    sym_t s = '0;
    s.is_zrl = 1'b1;
    s.run    = 4'd15;
    return s;
  endfunction

  function automatic sym_t e_eob();
    sym_t s = '0;
    s.is_eob = 1'b1;
    return s;
  endfunction

  // Monitor: a handshake seen after the falling edge completes at the next rise.
  initial begin
    sym_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_sym: got %0h expected none", bus.out_sym);
        end else begin
          e = exp_q.pop_front();
          check("sym", bus.out_sym, e);
        end
      end
    end
  end

  // Downstream: stalls for 5 cycles on the first ZRL once armed.
  initial begin
    sym_t held;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_arm && bus.out_valid && bus.out_sym.is_zrl) begin
        stall_arm     = 1'b0;
        bus.out_ready = 1'b0;
        held          = bus.out_sym;
        for (int k = 0; k < 5; k++) begin
          #2;
          check("stall_sym_stable", bus.out_sym, held);
          check("stall_in_ready", bus.in_ready, 1'b0);
          check("stall_out_valid", bus.out_valid, 1'b1);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic signed [10:0] d, input logic [1:0] c, input logic clr);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_comp  = c;
    dc_clr       = clr;
    #1;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    dc_clr       = 1'b0;
  endtask

  task automatic send_block(input int dc, input int comp, input logic clr,
                            input int nz_idx, input int nz_val);
    logic signed [10:0] d;
    d = 11'(dc);
    send(d, 2'(comp), clr);
    for (int i = 1; i < 64; i++) begin
      d = (i == nz_idx) ? 11'(nz_val) : 11'sd0;
      send(d, 2'(comp), 1'b0);
    end
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    #3;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t required completion", $time);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    dc_clr       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_comp  = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_sym", bus.out_sym, '0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("idle_in_ready", bus.in_ready, 1'b1);

    // DC 50, AC3 = -3
    exp_q.push_back(e_dc(6, 50));
    exp_q.push_back(e_ac(2, 2, 0));
    exp_q.push_back(e_eob());
    send_block(50, 0, 1'b0, 3, -3);
    drain();

    // AC35 = 1 after 34 zeros: two ZRLs then run 2
    exp_q.push_back(e_dc(0, 0));
    exp_q.push_back(e_zrl());
    exp_q.push_back(e_zrl());
    exp_q.push_back(e_ac(2, 1, 1));
    exp_q.push_back(e_eob());
    send_block(50, 0, 1'b0, 35, 1);
    drain();

    // Same block with a 5-cycle stall in the middle of the ZRL flush
    stall_arm = 1'b1;
    exp_q.push_back(e_dc(0, 0));
    exp_q.push_back(e_zrl());
    exp_q.push_back(e_zrl());
    exp_q.push_back(e_ac(2, 1, 1));
    exp_q.push_back(e_eob());
    send_block(50, 0, 1'b0, 35, 1);
    drain();
    check("stall_triggered", stall_arm, 1'b0);

    // All AC zero: DC -2 then EOB only
    exp_q.push_back(e_dc(2, 1));
    exp_q.push_back(e_eob());
    send_block(48, 0, 1'b0, 0, 0);
    drain();

    // AC63 = 5 after 62 zeros: three ZRLs, run 14, no EOB
    exp_q.push_back(e_dc(0, 0));
    exp_q.push_back(e_zrl());
    exp_q.push_back(e_zrl());
    exp_q.push_back(e_zrl());
    exp_q.push_back(e_ac(14, 3, 5));
    send_block(48, 0, 1'b0, 63, 5);
    drain();

    // Partial block on comp1, then reset mid-block
    exp_q.push_back(e_dc(7, 77));
    send(11'sd77, 2'd1, 1'b0);
    for (int i = 0; i < 10; i++) send(11'sd0, 2'd1, 1'b0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Per-component predictors: comp0=100, comp1=20, comp0=90
    exp_q.push_back(e_dc(7, 100));
    exp_q.push_back(e_eob());
    send_block(100, 0, 1'b0, 0, 0);
    exp_q.push_back(e_dc(5, 20));
    exp_q.push_back(e_eob());
    send_block(20, 1, 1'b0, 0, 0);
    exp_q.push_back(e_dc(4, 5));
    exp_q.push_back(e_eob());
    send_block(90, 0, 1'b0, 0, 0);
    drain();

    // dc_clr together with a comp0 DC of 90
    exp_q.push_back(e_dc(7, 90));
    exp_q.push_back(e_eob());
    send_block(90, 0, 1'b1, 0, 0);
    // comp1 was cleared too
    exp_q.push_back(e_dc(5, 20));
    exp_q.push_back(e_eob());
    send_block(20, 1, 1'b0, 0, 0);
    // the clear won over the load, so comp0 still predicts from 0
    exp_q.push_back(e_dc(3, 5));
    exp_q.push_back(e_eob());
    send_block(5, 0, 1'b0, 0, 0);
    drain();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rle_symbol_gen.md
RLE_SYMBOL_GEN -- requirements
Module: rle_symbol_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, signed coefficient width.
REQ-002 SHALL have parameter NUM_COMP, default 3, number of components, each with its own DC predictor.
REQ-003 SHALL have parameter BLOCK_LEN, default 64, coefficients per block in zigzag order (index 0 = DC).
REQ-004 SHALL have port clk, in, 1, the single clock.
REQ-005 SHALL have port rst, in, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port dc_clr, in, 1, synchronous clear of all DC predictors (restart marker).
REQ-007 SHALL have port in_valid, in, 1, coefficient valid.
REQ-008 SHALL have port in_ready, out, 1, coefficient accepted when in_valid && in_ready.
REQ-009 SHALL have port in_data, in, DATA_WIDTH, signed coefficient.
REQ-010 SHALL have port in_comp, in, clog2(NUM_COMP), component ID; sampled only at index 0.
REQ-011 SHALL have port out_valid, out, 1, symbol valid.
REQ-012 SHALL have port out_ready, in, 1, symbol consumed when out_valid && out_ready.
REQ-013 SHALL have port out_sym, out, sym_t, fields {isDC, isEOB, isZRL, run[3:0], size[SIZE_W-1:0], vli[DATA_WIDTH-1:0]}, with SIZE_W = clog2(DATA_WIDTH+2).

Function
REQ-014 SHALL use FSM states DC, AC, FLUSH, EOB, with DC as the reset state.
REQ-015 in_ready SHALL be (state==DC || state==AC) && (!out_valid || out_ready).
REQ-016 DC state, accept: diff = in_data - pred[in_comp], computed in DATA_WIDTH+1 bits with no overflow; SHALL emit an isDC symbol of diff; pred[in_comp] <= in_data; index <= 1; next state AC.
REQ-017 AC state, zero coefficient accepted: SHALL emit nothing; if run==15 then zrl_pend++ and run <= 0, else run++.
REQ-018 AC state, nonzero coefficient with zrl_pend==0: SHALL emit a symbol {run, size, vli}; run <= 0.
REQ-019 AC state, nonzero coefficient with zrl_pend>0: SHALL latch the coefficient and enter FLUSH.
REQ-020 FLUSH state: SHALL emit one ZRL symbol (run=15, size=0) per output handshake until zrl_pend==0, then emit the latched symbol.
REQ-021 At index BLOCK_LEN-1 with a zero coefficient: SHALL discard zrl_pend, enter EOB, and emit exactly one isEOB symbol (run=0, size=0).
REQ-022 At index BLOCK_LEN-1 with a nonzero coefficient: SHALL emit no EOB, and the next state after any flush SHALL be DC.
REQ-023 VLI: size = bit length of |v| (0 for v=0); vli = v for v>0, else (v-1) truncated to its low size bits; unused vli bits SHALL be 0.
REQ-024 Output register: out_sym SHALL be held stable while out_valid && !out_ready; no symbol is lost or duplicated.
REQ-025 zrl_pend SHALL be 2 bits wide; at most 3 ZRLs can be pending for BLOCK_LEN <= 64.
REQ-026 dc_clr SHALL take priority over a predictor load in the same cycle; a DC accepted in the same cycle SHALL use pred = 0.

Reset
REQ-027 rst SHALL force state=DC, all predictors=0, run=0, zrl_pend=0, index=0, out_valid=0, out_sym=0, in_ready=0 while rst is asserted.
REQ-028 Reset mid-block SHALL abandon the block; the first coefficient after reset SHALL be treated as a DC.

Structure
REQ-029 sym_t, SIZE_W and the FSM state enum SHALL live in shared package entropy_pkg.
REQ-030 VLI/size computation SHALL be a combinational sub-module vli_sizer, parameterised by input width and instanced once on a DC/AC operand mux.

Verification (DATA_WIDTH=11, NUM_COMP=3, BLOCK_LEN=64)
REQ-031 After reset, comp0 block DC=50, AC1..2=0, AC3=-3, rest 0 -> DC{size6, vli50}; {run2, size2, vli00}; EOB; 3 symbols total.
REQ-032 AC1..34=0, AC35=1, rest 0 -> ZRL, ZRL, {run2, size1, vli1}, EOB.
REQ-033 All AC=0 -> DC symbol followed only by EOB; no ZRLs.
REQ-034 AC1..62=0, AC63=5 -> ZRL x3, {run14, size3, vli101}; no EOB; next coefficient treated as DC.
REQ-035 DCs comp0=100, comp1=20, comp0=90 -> diffs 100, 20, -10 {size4, vli0101}; then dc_clr, comp0 DC=90 -> diff 90.
REQ-036 out_ready held low 5 cycles mid-FLUSH -> out_sym stable and in_ready=0 for those cycles; symbol sequence identical to the no-stall run.
